// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, decode opcodes and fetch FSM state type
package cpu_pkg;

  localparam int OPCODE_W = 6;
  localparam int INSTR_W  = 32;
  localparam int PC_STEP  = 4;

  localparam logic [OPCODE_W-1:0] LOAD  = 6'b000010;
  localparam logic [OPCODE_W-1:0] STORE = 6'b000011;
  localparam logic [OPCODE_W-1:0] BEQ   = 6'b010100;
  localparam logic [OPCODE_W-1:0] BNE   = 6'b010101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with reset, word increment and redirect load
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  // Redirect beats increment; targets are forced onto a word boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_en) begin
      pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (inc_en) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch with IR, redirect and kill
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [OPCODE_W-1:0] if_opcode,
  output logic [ADDR_W-1:0]   if_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc
);

  fetch_state_e       state, state_next;
  logic               kill, kill_next;
  logic               pc_inc, ir_load;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .inc_en      (pc_inc),
    .redirect_en (redirect_valid),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  always_comb begin
    state_next = state;
    kill_next  = kill;
    pc_inc     = 1'b0;
    ir_load    = 1'b0;
    unique case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_next = S_WAIT;
          // The request just accepted carries the pre-redirect address.
          if (redirect_valid) kill_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          kill_next = 1'b0;
          if (kill || redirect_valid) begin
            state_next = S_REQ;
          end else begin
            ir_load    = 1'b1;
            state_next = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_next = S_REQ;
        end else if (if_ready) begin
          pc_inc     = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      kill  <= 1'b0;
      ir    <= '0;
      ir_pc <= '0;
    end else begin
      state <= state_next;
      kill  <= kill_next;
      if (ir_load) begin
        ir    <= imem_rsp_data;
        ir_pc <= pc;
      end
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc;
  assign if_valid       = (state == S_HOLD);
  assign if_instr       = ir;
  assign if_opcode      = ir[INSTR_W-1 -: OPCODE_W];
  assign if_pc          = ir_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit against a memory and PC model
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  instr_fetch_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %b, required %b", name, act, req);
    end
  endtask

  // Instruction memory contents: a few fixed words, a hash of the address elsewhere.
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory responder: drives at negedge+1, observes the handshake just before posedge.
  int          mem_lat   = 0;
  int          ready_pct = 100;
  int          stray_pct = 0;
  logic        mem_pend  = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt  = 0;

  always begin
    @(negedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (mem_pend) begin
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        mem_pend       = 1'b0;
      end else begin
        pend_cnt--;
      end
    end else if (int'($urandom_range(0, 99)) < stray_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = (int'($urandom_range(0, 99)) < ready_pct);
    #3;
    if (!rst && imem_req_valid && imem_req_ready) begin
      mem_pend  = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
    end
  end

  // Reference model and monitor: architectural next-fetch PC plus queue of expected deliveries.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t      exp_q[$];
  fetch_t      cur;
  fetch_t      ent;
  logic [31:0] exp_pc     = RESET_PC;
  bit          held       = 1'b0;
  bit          prev_rst   = 1'b0;
  bit          gap_check  = 1'b0;
  bit          last_hs_ok = 1'b0;
  int          last_hs    = 0;
  int          cyc        = 0;
  int          idle_cyc   = 0;
  int          delivered  = 0;

  always begin
    @(negedge clk);
    #4;
    cyc++;
    if (prev_rst) begin
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_if_valid", if_valid, 1'b0);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_if_opcode", 32'(if_opcode), 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
    end
    if (rst) begin
      exp_pc     = RESET_PC;
      exp_q.delete();
      held       = 1'b0;
      last_hs_ok = 1'b0;
      idle_cyc   = 0;
    end else begin
      chk1("req_during_hold", imem_req_valid & if_valid, 1'b0);
      if (held) chk1("hold_valid", if_valid, 1'b1);
      if (if_valid) begin
        if (!held) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_instr: actual pc %h instr %h, required no delivery", if_pc, if_instr);
          end else begin
            cur = exp_q.pop_front();
            chk("deliver_pc", if_pc, cur.pc);
            chk("deliver_instr", if_instr, cur.instr);
            chk("deliver_opcode", 32'(if_opcode), 32'(cur.instr[31:26]));
            delivered++;
          end
          held     = 1'b1;
          idle_cyc = 0;
        end else begin
          chk("stable_instr", if_instr, cur.instr);
          chk("stable_pc", if_pc, cur.pc);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_addr, exp_pc);
        if (gap_check) begin
          if (last_hs_ok) chk("fetch_gap", 32'(cyc - last_hs), 32'd3);
          last_hs    = cyc;
          last_hs_ok = 1'b1;
        end else begin
          last_hs_ok = 1'b0;
        end
        if (!redirect_valid) begin
          ent.pc    = exp_pc;
          ent.instr = mem_word(exp_pc);
          exp_q.push_back(ent);
        end
      end
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
        exp_q.delete();
        held   = 1'b0;
      end else if (if_valid && if_ready) begin
        exp_pc = exp_pc + 32'd4;
        held   = 1'b0;
      end
      idle_cyc++;
      if (idle_cyc > 300) begin
        n_checks++;
        n_errors++;
        $display("FAIL progress: actual %0d cycles without delivery, required at most 300", idle_cyc);
        idle_cyc = 0;
      end
    end
    prev_rst = rst;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // which: 0 = if_valid, 1 = imem_req_valid, 2 = memory holding an accepted request
  task automatic wait_for(input int which, input string tag);
    for (int i = 0; i < 200; i++) begin
      if ((which == 0 && if_valid) || (which == 1 && imem_req_valid) || (which == 2 && mem_pend)) return;
      step();
    end
    n_checks++;
    n_errors++;
    $display("FAIL timeout_%s: actual no event in 200 cycles, required event", tag);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual still running, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    mem_ovr[32'h0] = 32'h0000_0000;
    mem_ovr[32'h4] = 32'h0800_0000;
    mem_ovr[32'h8] = 32'h5000_0010;

    // Reset, zero-latency memory, fetches at 0, 4, 8.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    wait_for(0, "p1_first");
    chk("p1_pc0", if_pc, 32'h0);
    chk("p1_op0", 32'(if_opcode), 32'h0);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    wait_for(0, "p1_second");
    chk("p1_pc1", if_pc, 32'h4);
    chk("p1_op1", 32'(if_opcode), 32'h2);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    wait_for(0, "p1_third");
    chk("p1_pc2", if_pc, 32'h8);
    chk("p1_instr2", if_instr, 32'h5000_0010);

    // Hold for five cycles, then release and stream back-to-back.
    repeat (5) step();
    chk1("p1_still_held", if_valid, 1'b1);
    if_ready  = 1'b1;
    gap_check = 1'b1;
    step();
    wait_for(1, "p1_next_req");
    chk("p1_next_addr", imem_addr, 32'hC);
    repeat (12) step();
    gap_check = 1'b0;

    // Redirect while waiting on the response.
    mem_lat = 2;
    wait_for(2, "p2_wait");
    do_redirect(32'h103);
    wait_for(1, "p2_req");
    chk("p2_target", imem_addr, 32'h100);

    // Redirect on the request handshake.
    mem_lat = 1;
    wait_for(1, "p3_req");
    do_redirect(32'h2468);
    wait_for(1, "p3_req2");
    chk("p3_target", imem_addr, 32'h2468);

    // Redirect while the request is stalled on ready.
    ready_pct = 0;
    step();
    wait_for(1, "p3b_req");
    do_redirect(32'h3001);
    chk1("p3b_req_held", imem_req_valid, 1'b1);
    chk("p3b_addr", imem_addr, 32'h3000);
    ready_pct = 100;

    // Redirect together with if_ready in hold.
    mem_lat  = 0;
    if_ready = 1'b0;
    wait_for(0, "p4_hold");
    if_ready = 1'b1;
    do_redirect(32'h4000);
    if_ready = 1'b0;
    chk1("p4_dropped", if_valid, 1'b0);
    wait_for(1, "p4_req");
    chk("p4_target", imem_addr, 32'h4000);

    // Wrap from the last word.
    do_redirect(32'hFFFF_FFFF);
    wait_for(0, "p5_hold");
    chk("p5_pc", if_pc, 32'hFFFF_FFFC);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    wait_for(1, "p5_req");
    chk("p5_wrap_addr", imem_addr, 32'h0);

    // Reset while waiting; the late response must be ignored.
    if_ready = 1'b1;
    mem_lat  = 1;
    wait_for(2, "p6_wait");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("p6_req_valid", imem_req_valid, 1'b0);
    chk1("p6_if_valid", if_valid, 1'b0);
    step();
    chk1("p6_ignored", if_valid, 1'b0);
    wait_for(1, "p6_req");
    chk("p6_reset_addr", imem_addr, RESET_PC);

    // Randomized traffic.
    mem_lat   = -1;
    ready_pct = 60;
    stray_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      if_ready       = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;
    stray_pct      = 0;
    if_ready       = 1'b1;
    repeat (30) step();
    chk1("random_deliveries", delivered > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
